// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle MIPS control path (main FSM and ALU control).
package mc_defs;

   // Instruction opcodes (ins_out[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Main FSM state encodings; 12..15 are unused and recover to S_IF
   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_MADR = 4'd2,
      S_MRD  = 4'd3,
      S_MWB  = 4'd4,
      S_MWR  = 4'd5,
      S_EXE  = 4'd6,
      S_RWB  = 4'd7,
      S_BR   = 4'd8,
      S_JMP  = 4'd9,
      S_IEX  = 4'd10,
      S_IWB  = 4'd11
   } state_t;

   // ALUOp codes
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU: Moore decode of the current
// state into datapath selects and write strobes, with strobes gated by en/rst.
module mc_ctrl
   import mc_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [5:0] opcode,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state
);

   state_t state_q;
   state_t state_d;

   // Ungated strobes; they only reach the datapath when stepping and out of reset
   logic pc_write_raw;
   logic pc_write_cond_raw;
   logic mem_write_raw;
   logic ir_write_raw;
   logic reg_write_raw;
   logic strobe_ok;

   // State register: reset forces IF, en = 0 freezes the sequence in place
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IF;
      end else if (en) begin
         state_q <= state_d;
      end
   end

   // Next-state logic; opcode only matters in ID and MADR
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF:   state_d = S_ID;
         S_ID: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MADR;
               OP_RTYPE:     state_d = S_EXE;
               OP_BEQ:       state_d = S_BR;
               OP_J:         state_d = S_JMP;
               OP_ADDI:      state_d = S_IEX;
               default:      state_d = S_IF;
            endcase
         end
         S_MADR: state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
         S_MRD:  state_d = S_MWB;
         S_MWB:  state_d = S_IF;
         S_MWR:  state_d = S_IF;
         S_EXE:  state_d = S_RWB;
         S_RWB:  state_d = S_IF;
         S_BR:   state_d = S_IF;
         S_JMP:  state_d = S_IF;
         S_IEX:  state_d = S_IWB;
         S_IWB:  state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   // Moore output decode; anything not set in a state stays at its zero default
   always_comb begin
      pc_write_raw      = 1'b0;
      pc_write_cond_raw = 1'b0;
      mem_write_raw     = 1'b0;
      ir_write_raw      = 1'b0;
      reg_write_raw     = 1'b0;
      IorD              = 1'b0;
      MemRead           = 1'b0;
      MemtoReg          = 1'b0;
      RegDst            = 1'b0;
      ALUSrcA           = 1'b0;
      ALUSrcB           = SRCB_REG;
      ALUOp             = ALUOP_ADD;
      PCSource          = PCSRC_ALU;
      case (state_q)
         S_IF: begin
            MemRead      = 1'b1;
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            ALUSrcB      = SRCB_FOUR;
         end
         S_ID: begin
            // Branch target computed speculatively into ALUOut
            ALUSrcB = SRCB_IMMSH2;
         end
         S_MADR, S_IEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MWR: begin
            mem_write_raw = 1'b1;
            IorD          = 1'b1;
         end
         S_MWB: begin
            reg_write_raw = 1'b1;
            MemtoReg      = 1'b1;
         end
         S_EXE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            reg_write_raw = 1'b1;
            RegDst        = 1'b1;
         end
         S_IWB: begin
            reg_write_raw = 1'b1;
         end
         S_BR: begin
            ALUSrcA           = 1'b1;
            ALUOp             = ALUOP_SUB;
            pc_write_cond_raw = 1'b1;
            PCSource          = PCSRC_ALUOUT;
         end
         S_JMP: begin
            pc_write_raw = 1'b1;
            PCSource     = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign strobe_ok   = en & ~rst;
   assign PCWrite     = pc_write_raw      & strobe_ok;
   assign PCWriteCond = pc_write_cond_raw & strobe_ok;
   assign MemWrite    = mem_write_raw     & strobe_ok;
   assign IRWrite     = ir_write_raw      & strobe_ok;
   assign RegWrite    = reg_write_raw     & strobe_ok;
   assign state       = state_q;

endmodule
